reg_bank_wb: RTL



---
 rtl/reg_bank_pkg.sv | 14 +
 rtl/reg_bank_wb_wr_queue.sv | 46 ++++
 rtl/reg_bank_wb.sv | 124 ++++++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the write-side register bank.
package reg_bank_pkg;
   localparam int DW     = 8;
   localparam int NREG   = 8;
   localparam int AW     = 3;
   localparam int QDEPTH = 2;

   typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

   typedef struct packed {
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
   } wr_entry_t;
endpackage

// File: rtl/reg_bank_wb_wr_queue.sv
// Two-entry in-order write queue; entry 0 is always the head.
module wr_queue
   import reg_bank_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  wr_entry_t                   push_entry,
   input  logic                        pop,
   output wr_entry_t                   head,
   output logic [1:0]                  count,
   output logic [QDEPTH-1:0]           valid,
   output logic [QDEPTH-1:0][AW-1:0]   entry_wa
);
   wr_entry_t  entries [QDEPTH];
   logic [1:0] count_reg;
   logic       do_pop;
   logic       do_push;
   logic       wr_idx;

   assign do_pop  = pop && (count_reg != 2'd0);
   assign do_push = push && ((count_reg < 2'(QDEPTH)) || do_pop);
   // Slot for the new entry is the occupancy after any pop: (count - pop) mod 2.
   assign wr_idx  = count_reg[0] ^ do_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= 2'd0;
         for (int i = 0; i < QDEPTH; i++) entries[i] <= '0;
      end else begin
         if (do_pop) entries[0] <= entries[1];
         if (do_push) entries[wr_idx] <= push_entry;
         count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign head  = entries[0];
   assign count = count_reg;

   generate
      for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
         assign valid[gi]    = (count_reg > 2'(gi));
         assign entry_wa[gi] = entries[gi].wa;
      end
   endgenerate
endmodule

// File: rtl/reg_bank_wb.sv
// Eight-register write-side bank: queued write-back commits, sequential clear, r0 hardwired to zero.
module reg_bank_wb
   import reg_bank_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_valid,
   output logic            wr_ready,
   input  logic [AW-1:0]   wa,
   input  logic [DW-1:0]   wd,
   input  logic            clr_req,
   output logic            clr_busy,
   output logic [NREG-1:0] pending,
   output logic [1:0]      q_count,
   output logic [DW-1:0]   D0,
   output logic [DW-1:0]   D1,
   output logic [DW-1:0]   D2,
   output logic [DW-1:0]   D3,
   output logic [DW-1:0]   D4,
   output logic [DW-1:0]   D5,
   output logic [DW-1:0]   D6,
   output logic [DW-1:0]   D7
);
   state_t                    state_reg;
   logic [AW-1:0]             idx_reg;
   logic [DW-1:0]             regs [1:NREG-1];
   logic                      push;
   logic                      pop;
   logic [1:0]                count_next;
   wr_entry_t                 push_entry;
   wr_entry_t                 head;
   logic [QDEPTH-1:0]         q_valid;
   logic [QDEPTH-1:0][AW-1:0] q_wa;

   assign wr_ready   = (state_reg == IDLE) && (q_count < 2'(QDEPTH));
   assign clr_busy   = (state_reg != IDLE);
   // Writes to r0 are acknowledged but never enter the queue.
   assign push       = wr_valid && wr_ready && (wa != '0);
   assign pop        = (state_reg != CLEAR) && (q_count != 2'd0);
   assign count_next = q_count + {1'b0, push} - {1'b0, pop};
   assign push_entry = '{wa: wa, wd: wd};

   wr_queue u_wr_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .count      (q_count),
      .valid      (q_valid),
      .entry_wa   (q_wa)
   );

   // A clear request that coincides with an accepted write drains it first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (clr_req) begin
                  if (count_next != 2'd0) begin
                     state_reg <= DRAIN;
                  end else begin
                     state_reg <= CLEAR;
                     idx_reg   <= AW'(1);
                  end
               end
            end
            DRAIN: begin
               if (count_next == 2'd0) begin
                  state_reg <= CLEAR;
                  idx_reg   <= AW'(1);
               end
            end
            CLEAR: begin
               if (idx_reg == AW'(NREG-1)) begin
                  state_reg <= IDLE;
                  idx_reg   <= '0;
               end else begin
                  idx_reg <= idx_reg + AW'(1);
               end
            end
            default: begin
               state_reg <= IDLE;
               idx_reg   <= '0;
            end
         endcase
      end
   end

   generate
      for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               regs[gi] <= '0;
            end else if ((state_reg == CLEAR) && (idx_reg == AW'(gi))) begin
               regs[gi] <= '0;
            end else if (pop && (head.wa == AW'(gi))) begin
               regs[gi] <= head.wd;
            end
         end
      end
   endgenerate

   always_comb begin
      pending = '0;
      for (int i = 0; i < QDEPTH; i++) begin
         if (q_valid[i]) pending[q_wa[i]] = 1'b1;
      end
      pending[0] = 1'b0;
   end

   assign D0 = '0;
   assign D1 = regs[1];
   assign D2 = regs[2];
   assign D3 = regs[3];
   assign D4 = regs[4];
   assign D5 = regs[5];
   assign D6 = regs[6];
   assign D7 = regs[7];
endmodule
